// File: rtl/debug_pkg.sv
// Shared constants for the UART debug sequencer: command bytes, FSM encoding
// and dump framing.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam int WORD_BYTES = 4;
  localparam int NUM_REGS   = 32;
  localparam int DUMP_BYTES = WORD_BYTES * (NUM_REGS + 1);

  typedef logic [3:0] state_t;

  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_LOAD_COUNT   = 4'd1;
  localparam logic [3:0] ST_LOAD_BYTE    = 4'd2;
  localparam logic [3:0] ST_LOAD_WRITE   = 4'd3;
  localparam logic [3:0] ST_LOAD_DONE    = 4'd4;
  localparam logic [3:0] ST_RUN          = 4'd5;
  localparam logic [3:0] ST_STEP         = 4'd6;
  localparam logic [3:0] ST_DUMP_PC      = 4'd7;
  localparam logic [3:0] ST_DUMP_PC_SEND = 4'd8;
  localparam logic [3:0] ST_DUMP_ADDR    = 4'd9;
  localparam logic [3:0] ST_DUMP_WAIT    = 4'd10;
  localparam logic [3:0] ST_DUMP_SEND    = 4'd11;

  // Maps a byte received in IDLE to the state it starts; unknown bytes stay idle.
  function automatic state_t cmd_to_state(input logic [7:0] cmd);
    state_t nxt;
    case (cmd)
      CMD_LOAD: nxt = ST_LOAD_COUNT;
      CMD_CONT: nxt = ST_RUN;
      CMD_STEP: nxt = ST_STEP;
      default:  nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// Sends one word as MSB-first bytes over a valid/ready byte interface.
module debug_tx_serializer
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [7:0]            bytes_left;
  logic                  busy;
  logic                  accept;

  assign accept   = busy && tx_ready;
  assign tx_data  = shift_reg[DATA_WIDTH-1 -: 8];
  assign tx_valid = busy;
  assign done     = accept && (bytes_left == 8'd1);

  // Data only shifts on acceptance, so the byte on tx_data is stable while stalled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_reg  <= '0;
      bytes_left <= '0;
      busy       <= 1'b0;
    end else if (load) begin
      shift_reg  <= word;
      bytes_left <= 8'(DATA_WIDTH / 8);
      busy       <= 1'b1;
    end else if (accept) begin
      shift_reg  <= {shift_reg[DATA_WIDTH-9:0], 8'h00};
      bytes_left <= bytes_left - 8'd1;
      if (bytes_left == 8'd1) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/debug_controller.sv
// UART debug sequencer: loads imem, runs or single-steps the pipeline, and
// dumps the PC plus all registers to the host after each run or step.
//
// state           | meaning
// ST_IDLE         | waiting for a command byte
// ST_LOAD_COUNT   | waiting for the word count N
// ST_LOAD_BYTE    | shifting in 4 bytes of the next word, MSB first
// ST_LOAD_WRITE   | one-cycle imem write of the assembled word
// ST_LOAD_DONE    | one-cycle pipeline reset pulse, clears halted
// ST_RUN          | pipeline enabled until i_halt
// ST_STEP         | single enable cycle unless already halted
// ST_DUMP_PC      | latch i_pc into the serializer
// ST_DUMP_PC_SEND | sending the 4 PC bytes
// ST_DUMP_ADDR    | drive register address to the bank
// ST_DUMP_WAIT    | bank data valid, latch into the serializer
// ST_DUMP_SEND    | sending the 4 register bytes
module debug_controller
  import debug_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_tx_ready,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0]      o_imem_data,
  output logic                       o_pipe_enable,
  output logic                       o_pipe_reset,
  input  logic                       i_halt,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [REG_ADDR_WIDTH-1:0]  o_dbg_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_dbg_reg_data
);

  state_t                    state;
  logic                      halted;
  logic [7:0]                word_cnt;
  logic [7:0]                word_idx;
  logic [1:0]                byte_cnt;
  logic [DATA_WIDTH-1:0]     asm_word;
  logic [REG_ADDR_WIDTH-1:0] reg_idx;
  logic [7:0]                bytes_left;

  logic                      ser_load;
  logic [DATA_WIDTH-1:0]     ser_word;
  logic                      ser_done;
  logic                      tx_accept;

  assign tx_accept = o_tx_valid && i_tx_ready;

  assign o_imem_we      = (state == ST_LOAD_WRITE);
  assign o_imem_addr    = IMEM_ADDR_WIDTH'(word_idx);
  assign o_imem_data    = asm_word;
  assign o_pipe_reset   = (state == ST_LOAD_DONE);
  assign o_dbg_reg_addr = reg_idx;

  // i_halt gates the enable combinationally so the halt cycle itself never advances.
  assign o_pipe_enable = !halted &&
                         (((state == ST_RUN) && !i_halt) || (state == ST_STEP));

  assign ser_load = (state == ST_DUMP_PC) || (state == ST_DUMP_WAIT);
  assign ser_word = (state == ST_DUMP_PC) ? i_pc : i_dbg_reg_data;

  debug_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tx_ser (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .load     (ser_load),
    .word     (ser_word),
    .tx_ready (i_tx_ready),
    .tx_data  (o_tx_data),
    .tx_valid (o_tx_valid),
    .done     (ser_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      halted     <= 1'b0;
      word_cnt   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      reg_idx    <= '0;
      bytes_left <= '0;
    end else begin
      if (tx_accept) begin
        bytes_left <= bytes_left - 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            state <= cmd_to_state(i_rx_data);
          end
        end

        ST_LOAD_COUNT: begin
          if (i_rx_valid) begin
            if (i_rx_data == 8'd0) begin
              state <= ST_IDLE;
            end else begin
              word_cnt <= i_rx_data;
              word_idx <= '0;
              byte_cnt <= '0;
              state    <= ST_LOAD_BYTE;
            end
          end
        end

        ST_LOAD_BYTE: begin
          if (i_rx_valid) begin
            asm_word <= {asm_word[DATA_WIDTH-9:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= ST_LOAD_WRITE;
            end
          end
        end

        ST_LOAD_WRITE: begin
          word_idx <= word_idx + 8'd1;
          if (word_idx == word_cnt - 8'd1) begin
            state <= ST_LOAD_DONE;
          end else begin
            state <= ST_LOAD_BYTE;
          end
        end

        ST_LOAD_DONE: begin
          halted <= 1'b0;
          state  <= ST_IDLE;
        end

        ST_RUN: begin
          if (halted) begin
            state <= ST_DUMP_PC;
          end else if (i_halt) begin
            halted <= 1'b1;
            state  <= ST_DUMP_PC;
          end
        end

        ST_STEP: begin
          if (!halted && i_halt) begin
            halted <= 1'b1;
          end
          state <= ST_DUMP_PC;
        end

        ST_DUMP_PC: begin
          bytes_left <= 8'(DUMP_BYTES);
          reg_idx    <= '0;
          state      <= ST_DUMP_PC_SEND;
        end

        ST_DUMP_PC_SEND: begin
          if (ser_done) begin
            state <= ST_DUMP_ADDR;
          end
        end

        ST_DUMP_ADDR: begin
          state <= ST_DUMP_WAIT;
        end

        ST_DUMP_WAIT: begin
          state <= ST_DUMP_SEND;
        end

        ST_DUMP_SEND: begin
          if (ser_done) begin
            if (bytes_left == 8'd1) begin
              state <= ST_IDLE;
            end else begin
              reg_idx <= reg_idx + REG_ADDR_WIDTH'(1);
              state   <= ST_DUMP_ADDR;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: load, run, step, halted behaviour,
// tx backpressure and reset in the middle of a dump.
module tb_debug_controller;
  import debug_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_tx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_imem_we;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_pipe_enable;
  logic        o_pipe_reset;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [4:0]  o_dbg_reg_addr;
  logic [31:0] i_dbg_reg_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] imem_model [0:1023];
  int          wr_cnt = 0, rst_cnt = 0, en_cnt = 0, rst_at_wr = 0, stab_err = 0;
  logic [7:0]  tx_q [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        bp_mode = 1'b0;
  int          cyc = 0;

  always #5 i_clk = ~i_clk;

  debug_controller #(
    .DATA_WIDTH      (32),
    .REG_ADDR_WIDTH  (5),
    .IMEM_ADDR_WIDTH (10)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .o_imem_we      (o_imem_we),
    .o_imem_addr    (o_imem_addr),
    .o_imem_data    (o_imem_data),
    .o_pipe_enable  (o_pipe_enable),
    .o_pipe_reset   (o_pipe_reset),
    .i_halt         (i_halt),
    .i_pc           (i_pc),
    .o_dbg_reg_addr (o_dbg_reg_addr),
    .i_dbg_reg_data (i_dbg_reg_data)
  );

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (r == 5'd1) return 32'h0000_0005;
    return 32'hC0DE_0000 | {19'b0, r, 3'b0, r};
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pc);
    logic [31:0] w;
    w = (i < 4) ? pc : reg_val(5'((i - 4) / 4));
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  function automatic logic [7:0] q_at(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hxx;
  endfunction

  // Register bank model: read data valid one cycle after the address.
  always @(posedge i_clk) i_dbg_reg_data <= reg_val(o_dbg_reg_addr);

  always @(negedge i_clk) begin
    if (o_imem_we) begin
      imem_model[o_imem_addr] = o_imem_data;
      wr_cnt++;
    end
    if (o_pipe_reset) begin
      rst_cnt++;
      rst_at_wr = wr_cnt;
    end
    if (o_pipe_enable) en_cnt++;
    if (bp_mode && prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) stab_err++;
    if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
    prev_stall = o_tx_valid && !i_tx_ready;
    prev_data  = o_tx_data;
  end

  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      i_tx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
    step(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dump(input int bound);
    int k = 0;
    while (tx_q.size() < DUMP_BYTES && k < bound) begin
      step(1);
      k++;
    end
    step(4);
  endtask

  task automatic check_dump(input string tag, input logic [31:0] pc);
    int bad = 0;
    check({tag, "_len"}, 32'(tx_q.size()), 32'(DUMP_BYTES));
    for (int i = 0; i < DUMP_BYTES; i++) begin
      if (q_at(i) !== exp_byte(i, pc)) bad++;
    end
    check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
    check({tag, "_pc"}, {q_at(0), q_at(1), q_at(2), q_at(3)}, pc);
    check({tag, "_r1"}, {q_at(8), q_at(9), q_at(10), q_at(11)}, 32'h0000_0005);
    check({tag, "_tx_idle"}, 32'(o_tx_valid), 32'd0);
    tx_q.delete();
  endtask

  initial begin
    int base_en, base_wr, base_rst, k;
    i_reset    = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    i_pc       = 32'h0;
    step(3);
    check("rst_enable", 32'(o_pipe_enable), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_imem_we", 32'(o_imem_we), 32'd0);
    check("rst_pipe_reset", 32'(o_pipe_reset), 32'd0);
    check("rst_imem_addr", 32'(o_imem_addr), 32'd0);
    check("rst_imem_data", o_imem_data, 32'd0);
    check("rst_dbg_addr", 32'(o_dbg_reg_addr), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    i_reset = 1'b0;
    step(2);

    send(8'h7A);
    step(2);
    check("junk_state", 32'(dut.state), 32'(ST_IDLE));
    check("junk_no_tx", 32'(tx_q.size()), 32'd0);
    check("junk_no_wr", 32'(wr_cnt), 32'd0);

    send(CMD_LOAD); send(8'h02);
    send(8'h20); send(8'h01); send(8'h00); send(8'h05);
    send(8'h00); send(8'h00); send(8'h00); send(8'h3F);
    step(4);
    check("load_imem0", imem_model[0], 32'h2001_0005);
    check("load_imem1", imem_model[1], 32'h0000_003F);
    check("load_wr_cnt", 32'(wr_cnt), 32'd2);
    check("load_rst_cnt", 32'(rst_cnt), 32'd1);
    check("load_rst_after_wr", 32'(rst_at_wr), 32'd2);

    i_pc = 32'h0040_0024;
    base_en = en_cnt;
    send(CMD_CONT);
    k = 0;
    while (en_cnt - base_en < 7 && k < 200) begin
      step(1);
      k++;
    end
    i_halt = 1'b1;
    step(1);
    i_halt = 1'b0;
    wait_dump(1000);
    check("cont_enable_cycles", 32'(en_cnt - base_en), 32'd7);
    check_dump("cont", 32'h0040_0024);

    i_pc = 32'h0040_0028;
    base_en = en_cnt;
    send(CMD_CONT);
    wait_dump(1000);
    check("halted_cont_no_enable", 32'(en_cnt - base_en), 32'd0);
    check_dump("halted_cont", 32'h0040_0028);
    base_en = en_cnt;
    send(CMD_STEP);
    wait_dump(1000);
    check("halted_step_no_enable", 32'(en_cnt - base_en), 32'd0);
    check_dump("halted_step", 32'h0040_0028);

    base_rst = rst_cnt;
    send(CMD_LOAD); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    step(4);
    check("reload_imem0", imem_model[0], 32'hDEAD_BEEF);
    check("reload_rst_pulse", 32'(rst_cnt - base_rst), 32'd1);

    i_pc = 32'h0000_0008;
    base_en = en_cnt;
    send(CMD_STEP);
    wait_dump(1000);
    check("step1_enable", 32'(en_cnt - base_en), 32'd1);
    check_dump("step1", 32'h0000_0008);
    i_pc = 32'h0000_000C;
    base_en = en_cnt;
    send(CMD_STEP);
    wait_dump(1000);
    check("step2_enable", 32'(en_cnt - base_en), 32'd1);
    check_dump("step2", 32'h0000_000C);

    bp_mode  = 1'b1;
    stab_err = 0;
    i_pc = 32'h1234_5678;
    send(CMD_STEP);
    wait_dump(3000);
    bp_mode = 1'b0;
    check_dump("bp", 32'h1234_5678);
    check("bp_stable", 32'(stab_err), 32'd0);

    base_wr  = wr_cnt;
    base_rst = rst_cnt;
    send(CMD_LOAD); send(8'h00);
    step(3);
    check("n0_no_write", 32'(wr_cnt - base_wr), 32'd0);
    check("n0_no_reset", 32'(rst_cnt - base_rst), 32'd0);
    check("n0_state", 32'(dut.state), 32'(ST_IDLE));

    i_pc = 32'h0000_0040;
    send(CMD_STEP);
    k = 0;
    while (tx_q.size() < 50 && k < 1000) begin
      step(1);
      k++;
    end
    check("mid_dump_reached_50", 32'(tx_q.size() >= 50), 32'd1);
    i_reset = 1'b1;
    step(1);
    check("mid_rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    check("mid_rst_enable", 32'(o_pipe_enable), 32'd0);
    i_reset = 1'b0;
    step(1);
    tx_q.delete();
    base_en = en_cnt;
    send(CMD_STEP);
    wait_dump(1000);
    check("post_rst_enable", 32'(en_cnt - base_en), 32'd1);
    check_dump("post_rst", 32'h0000_0040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
